sprite_tex_loader: RTL and testbench

Write-side sequencer for the sprite texture RAMs inside the sprite renderer. On a start pulse it fetches the bird, pipe and ground textures from SDRAM in that order. Each fetch is a read request followed by a ready/valid word stream. Every accepted word is replayed as a one-cycle write strobe on the renderer's bird, pipe or base load port, with a per-texture address counter running from 0.

---
 rtl/sprite_tex_loader.sv | 84 ++++++++
 tb/tb_sprite_tex_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sprite_tex_loader.sv
// sprite_tex_loader: fetches bird, pipe and ground textures from SDRAM and replays
// each accepted word as a one-cycle write strobe on the matching renderer load port.
module sprite_tex_loader #(
  parameter int          BIRD_WORDS = 5250,
  parameter int          PIPE_WORDS = 40000,
  parameter int          BASE_WORDS = 9600,
  parameter logic [23:0] BIRD_SRC   = 24'h000000,
  parameter logic [23:0] PIPE_SRC   = 24'h002000,
  parameter logic [23:0] BASE_SRC   = 24'h00C000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [15:0] rd_len,
  input  logic        rd_ack,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  output logic [15:0] load_data,
  output logic        bird_load_en,
  output logic [12:0] bird_load_addr,
  output logic        pipe_load_en,
  output logic [15:0] pipe_load_addr,
  output logic        base_load_en,
  output logic [13:0] base_load_addr,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {
    IDLE, REQ_BIRD, LOAD_BIRD, REQ_PIPE, LOAD_PIPE, REQ_BASE, LOAD_BASE, DONE
  } state_t;
  state_t state, state_nx;
  logic [15:0] wcnt, last;
  logic beat, fin, ack, req_entry;
  // Each REQ/LOAD pair is followed by the next texture's pair, so advancing is state+1.
  always_comb begin
    rd_req    = state inside {REQ_BIRD, REQ_PIPE, REQ_BASE};
    src_ready = state inside {LOAD_BIRD, LOAD_PIPE, LOAD_BASE};
    busy      = !(state inside {IDLE, DONE});
    done      = state == DONE;
    last      = state == LOAD_BIRD ? 16'(BIRD_WORDS - 1) :
                state == LOAD_PIPE ? 16'(PIPE_WORDS - 1) : 16'(BASE_WORDS - 1);
    beat      = src_valid && src_ready;
    fin       = beat && wcnt == last;
    ack       = rd_req && rd_ack;
    state_nx  = (state == IDLE || state == DONE) ? (start ? REQ_BIRD : state) :
                (rd_req ? ack : fin) ? state_t'(state + 3'd1) : state;
    req_entry = state_nx != state && state_nx inside {REQ_BIRD, REQ_PIPE, REQ_BASE};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt           <= '0;
      rd_addr        <= '0;
      rd_len         <= '0;
      load_data      <= '0;
      bird_load_en   <= 1'b0;
      pipe_load_en   <= 1'b0;
      base_load_en   <= 1'b0;
      bird_load_addr <= '0;
      pipe_load_addr <= '0;
      base_load_addr <= '0;
    end else begin
      wcnt <= req_entry ? 16'd0 : beat ? wcnt + 16'd1 : wcnt;
      if (req_entry) begin
        rd_addr <= state_nx == REQ_BIRD ? BIRD_SRC : state_nx == REQ_PIPE ? PIPE_SRC : BASE_SRC;
        rd_len  <= state_nx == REQ_BIRD ? 16'(BIRD_WORDS) :
                   state_nx == REQ_PIPE ? 16'(PIPE_WORDS) : 16'(BASE_WORDS);
      end
      bird_load_en <= beat && state == LOAD_BIRD;
      pipe_load_en <= beat && state == LOAD_PIPE;
      base_load_en <= beat && state == LOAD_BASE;
      if (beat) load_data <= src_data;
      if (beat && state == LOAD_BIRD) bird_load_addr <= wcnt[12:0];
      if (beat && state == LOAD_PIPE) pipe_load_addr <= wcnt;
      if (beat && state == LOAD_BASE) base_load_addr <= wcnt[13:0];
    end
  end
endmodule

// File: tb/tb_sprite_tex_loader.sv
// tb_sprite_tex_loader: reduced-size loader driven by a word-stream source model, plus a
// full-size loader streaming continuously to confirm counts and final addresses.
module tb_sprite_tex_loader;
  localparam int NB = 4, NP = 6, NS = 3, TOT = NB + NP + NS;
  localparam logic [23:0] SRC [3] = '{24'h000000, 24'h002000, 24'h00C000};
  localparam int LEN [3] = '{NB, NP, NS};

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rd_ack = 1'b0, src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic rd_req, src_ready, load_en_b, load_en_p, load_en_s, busy, done;
  logic [23:0] rd_addr;
  logic [15:0] rd_len, load_data, addr_p;
  logic [12:0] addr_b;
  logic [13:0] addr_s;

  logic f_rst = 1'b1, f_start = 1'b0, f_valid = 1'b1;
  logic [15:0] f_data = '0;
  logic f_req, f_ready, f_en_b, f_en_p, f_en_s, f_busy, f_done, f_ack;
  logic [23:0] f_addr;
  logic [15:0] f_len, f_ld, f_addr_p;
  logic [12:0] f_addr_b;
  logic [13:0] f_addr_s;

  int checks = 0, errors = 0;
  int n_b = 0, n_p = 0, n_s = 0, f_bad = 0, last_p = -1, last_s = -1;

  always #5 clk = ~clk;

  sprite_tex_loader #(.BIRD_WORDS(NB), .PIPE_WORDS(NP), .BASE_WORDS(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .load_data(load_data), .bird_load_en(load_en_b), .bird_load_addr(addr_b),
    .pipe_load_en(load_en_p), .pipe_load_addr(addr_p), .base_load_en(load_en_s),
    .base_load_addr(addr_s), .busy(busy), .done(done));

  sprite_tex_loader full (
    .clk(clk), .rst(f_rst), .start(f_start), .rd_req(f_req), .rd_addr(f_addr), .rd_len(f_len),
    .rd_ack(f_ack), .src_valid(f_valid), .src_data(f_data), .src_ready(f_ready),
    .load_data(f_ld), .bird_load_en(f_en_b), .bird_load_addr(f_addr_b),
    .pipe_load_en(f_en_p), .pipe_load_addr(f_addr_p), .base_load_en(f_en_s),
    .base_load_addr(f_addr_s), .busy(f_busy), .done(f_done));

  assign f_ack = f_req;
  always @(posedge clk) if (f_valid && f_ready) f_data <= f_data + 16'd1;

  // Full-size monitor: addresses must run contiguously per texture, one enable at most.
  always @(negedge clk) if (!f_rst) begin
    if ($countones({f_en_b, f_en_p, f_en_s}) > 1) f_bad++;
    if (f_en_b) begin if (int'(f_addr_b) != n_b) f_bad++; n_b++; end
    if (f_en_p) begin if (int'(f_addr_p) != n_p) f_bad++; n_p++; last_p = int'(f_addr_p); end
    if (f_en_s) begin if (int'(f_addr_s) != n_s) f_bad++; n_s++; last_s = int'(f_addr_s); end
    if (f_done != (n_s == 9600)) f_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({rd_req, src_ready, busy, done, load_en_b, load_en_p, load_en_s}), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_rd_len"}, 32'(rd_len), 0);
    chk({tag, "_load_data"}, 32'(load_data), 0);
    chk({tag, "_addrs"}, 32'(addr_b) | 32'(addr_p) | 32'(addr_s), 0);
  endtask

  // mode 0: ack at once, valid always; 1: ack after 5 cycles, valid 1,0,0,1,1,0; 2: random.
  task automatic run(input int mode, input int start_at, input int rst_at);
    logic [15:0] stream [TOT];
    bit [5:0] pat = 6'b011001;
    int sent = 0, got = 0, req_i = 0, wait_ack, cyc = 0, t, idx;
    bit beat = 0, pulsed = 0;
    for (int i = 0; i < TOT; i++) stream[i] = mode == 0 ? 16'h0100 + 16'(i) : 16'($urandom);
    wait_ack = mode == 1 ? 5 : mode == 2 ? int'($urandom_range(0, 5)) : 0;
    @(posedge clk); #1 start = 1'b1;
    while (got < TOT && cyc < 500) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) chk("req_after_start", 32'(rd_req), 1);
      t = got < NB ? 0 : got < NB + NP ? 1 : 2;
      idx = got - (t == 0 ? 0 : t == 1 ? NB : NB + NP);
      chk("enables", 32'({load_en_s, load_en_p, load_en_b}), beat ? 32'(1) << t : 0);
      if (beat) begin
        chk("load_data", 32'(load_data), 32'(stream[got]));
        chk("load_addr", t == 0 ? 32'(addr_b) : t == 1 ? 32'(addr_p) : 32'(addr_s), 32'(idx));
        got++;
      end
      chk("done", 32'(done), 32'(got == TOT));
      chk("busy", 32'(busy), 32'(got != TOT));
      if (rd_req) begin
        chk("req_in_range", 32'(req_i < 3), 1);
        chk("rd_addr", 32'(rd_addr), 32'(SRC[req_i < 3 ? req_i : 2]));
        chk("rd_len", 32'(rd_len), 32'(LEN[req_i < 3 ? req_i : 2]));
        chk("ready_in_req", 32'(src_ready), 0);
      end
      if (rst_at >= 0 && got == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_zero("abort");
        src_valid = 1'b0;
        rd_ack = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      if (start_at >= 0 && got == start_at && !pulsed) begin start = 1'b1; pulsed = 1; end
      src_valid = sent < TOT && (mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 6] : $urandom_range(0, 3) != 0);
      src_data = sent < TOT ? stream[sent] : 16'($urandom);
      rd_ack = rd_req && wait_ack == 0;
      if (rd_req && wait_ack > 0) wait_ack--;
      beat = src_valid && src_ready;
      if (beat) sent++;
      if (rd_req && rd_ack) begin
        req_i++;
        wait_ack = mode == 1 ? 5 : mode == 2 ? int'($urandom_range(0, 5)) : 0;
      end
    end
    chk("complete", 32'(got), TOT);
    chk("req_count", 32'(req_i), 3);
    if (mode == 0) chk("cycles", 32'(cyc), TOT + 4);
    src_valid = 1'b1;
    rd_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_state", 32'({done, busy, src_ready, load_en_b, load_en_p, load_en_s}), 32'b100000);
    end
    src_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    f_rst = 1'b0;
    f_start = 1'b1;
    src_valid = 1'b1;
    @(posedge clk); #1 f_start = 1'b0;
    chk("idle_no_req", 32'({rd_req, src_ready, busy, done}), 0);
    src_valid = 1'b0;
    run(0, -1, -1);
    run(0, NB + 1, -1);
    run(1, -1, -1);
    run(2, -1, NB + 3);
    run(0, -1, -1);
    for (int k = 0; k < 4; k++) run(2, -1, -1);
    for (int i = 0; i < 60000 && !f_done; i++) @(posedge clk);
    #1;
    chk("full_done", 32'(f_done), 1);
    chk("full_bird_count", 32'(n_b), 5250);
    chk("full_pipe_count", 32'(n_p), 40000);
    chk("full_base_count", 32'(n_s), 9600);
    chk("full_pipe_last", 32'(last_p), 39999);
    chk("full_base_last", 32'(last_s), 9599);
    chk("full_monitor", 32'(f_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
